// File: rtl/mc_control_v2.sv
// Multicycle RV32I control FSM for the mp2 datapath: mux selects, loads and strobes,
// plus sticky traps, instruction-boundary halt, retired-instruction count and latched EA bits.
//
// state     | meaning
// FETCH1    | MAR <- PC, or divert to HALT when halt_req is set
// FETCH2    | instruction read, wait for mem_resp
// FETCH3    | IR <- MDR
// DECODE    | classify opcode, trap on illegal opcode / branch funct3
// EXEC      | single-cycle execute of all non-memory ops
// CALC_ADDR | effective address, legality and alignment checks
// LD1       | data read, wait for mem_resp
// LD2       | writeback of loaded data
// ST1       | data write, wait for mem_resp
// ST2       | PC advance after store
// TRAP      | sticky fault, left only by rst
// HALT      | parked between instructions while halt_req is high
module mc_control_v2 #(
  parameter int unsigned MEM_TIMEOUT   = 0,
  parameter bit          MISALIGN_TRAP = 1'b1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             br_en,
  input  logic [1:0]       addr_lsb,
  input  logic             mem_resp,
  input  logic             halt_req,
  output logic [1:0]       pcmux_sel,
  output logic             alumux1_sel,
  output logic [2:0]       alumux2_sel,
  output logic [3:0]       regfilemux_sel,
  output logic             marmux_sel,
  output logic             cmpmux_sel,
  output logic [2:0]       aluop,
  output logic [2:0]       cmpop,
  output logic             mem_read,
  output logic             mem_write,
  output logic [3:0]       mem_byte_enable,
  output logic [3:0]       rmask,
  output logic [3:0]       wmask,
  output logic             load_pc,
  output logic             load_ir,
  output logic             load_regfile,
  output logic             load_mar,
  output logic             load_mdr,
  output logic             load_data_out,
  output logic             trap,
  output logic [2:0]       trap_cause,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

  localparam logic [1:0] PC_PLUS4 = 2'd0, PC_ALU = 2'd1, PC_ALU_MOD2 = 2'd2;
  localparam logic       ALU1_RS1 = 1'b0, ALU1_PC = 1'b1;
  localparam logic [2:0] ALU2_I = 3'd0, ALU2_U = 3'd1, ALU2_B = 3'd2, ALU2_S = 3'd3;
  localparam logic [2:0] ALU2_J = 3'd4, ALU2_RS2 = 3'd5;
  localparam logic [3:0] RF_ALU = 4'd0, RF_BR = 4'd1, RF_U = 4'd2, RF_LW = 4'd3, RF_PC4 = 4'd4;
  localparam logic [3:0] RF_LB = 4'd5, RF_LBU = 4'd6, RF_LH = 4'd7, RF_LHU = 4'd8;
  localparam logic       MAR_PC = 1'b0, MAR_ALU = 1'b1;
  localparam logic       CMP_RS2 = 1'b0, CMP_I = 1'b1;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SRA = 3'd2, ALU_SUB = 3'd3, ALU_SRL = 3'd5;
  localparam logic [2:0] F3_BLT = 3'b100, F3_BLTU = 3'b110;

  localparam logic [2:0] CAUSE_NONE = 3'd0, CAUSE_OPCODE = 3'd1, CAUSE_FUNCT3 = 3'd2;
  localparam logic [2:0] CAUSE_MIS_LD = 3'd3, CAUSE_MIS_ST = 3'd4, CAUSE_TIMEOUT = 3'd5;

  localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, DECODE, EXEC, CALC_ADDR,
    LD1, LD2, ST1, ST2, TRAP, HALT
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       addr_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [2:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q;
  logic             in_wait, timeout_hit, ls_bad_f3, ls_misaligned;
  logic [3:0]       lane_q;

  // Lane mask from access size; the 4-bit shift deliberately drops lanes past byte 3.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b10:   return 4'b1111;
      2'b01:   return 4'b0011 << a;
      default: return 4'b0001 << a;
    endcase
  endfunction

  assign in_wait     = (state_q == FETCH2) || (state_q == LD1) || (state_q == ST1);
  assign timeout_hit = (MEM_TIMEOUT != 0) && in_wait && !mem_resp &&
                       (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));
  assign lane_q      = lane_mask(funct3, addr_q);

  assign ls_bad_f3 = (opcode == OP_LOAD) ?
                     !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) :
                     !(funct3 inside {3'b000, 3'b001, 3'b010});
  assign ls_misaligned = ((funct3[1:0] == 2'b10) && (addr_lsb != 2'b00)) ||
                         ((funct3[1:0] == 2'b01) && addr_lsb[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH1;
      addr_q    <= 2'b00;
      to_cnt_q  <= '0;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CALC_ADDR) addr_q <= addr_lsb;
      if (in_wait && state_d == state_q) to_cnt_q <= to_cnt_q + 1'b1;
      else                               to_cnt_q <= '0;
      if (state_d == TRAP && state_q != TRAP) cause_q <= cause_d;
      if (load_pc) instret_q <= instret_q + 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    cause_d         = CAUSE_NONE;
    pcmux_sel       = PC_PLUS4;
    alumux1_sel     = ALU1_RS1;
    alumux2_sel     = ALU2_I;
    regfilemux_sel  = RF_ALU;
    marmux_sel      = MAR_PC;
    cmpmux_sel      = CMP_RS2;
    aluop           = ALU_ADD;
    cmpop           = funct3;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = 4'b1111;
    rmask           = 4'b0000;
    wmask           = 4'b0000;
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_regfile    = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    load_data_out   = 1'b0;

    case (state_q)
      FETCH1: begin
        if (halt_req) state_d = HALT;
        else begin
          load_mar = 1'b1;
          state_d  = FETCH2;
        end
      end
      FETCH2: begin
        mem_read = 1'b1;
        load_mdr = 1'b1;
        if (mem_resp) state_d = FETCH3;
        else if (timeout_hit) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      FETCH3: begin
        load_ir = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG: state_d = EXEC;
          OP_LOAD, OP_STORE: state_d = CALC_ADDR;
          OP_BR: begin
            if (funct3 inside {3'b010, 3'b011}) begin
              state_d = TRAP;
              cause_d = CAUSE_FUNCT3;
            end else state_d = EXEC;
          end
          default: begin
            state_d = TRAP;
            cause_d = CAUSE_OPCODE;
          end
        endcase
      end
      EXEC: begin
        load_pc      = 1'b1;
        load_regfile = 1'b1;
        state_d      = FETCH1;
        case (opcode)
          OP_LUI:   regfilemux_sel = RF_U;
          OP_AUIPC: begin
            alumux1_sel = ALU1_PC;
            alumux2_sel = ALU2_U;
          end
          OP_JAL: begin
            alumux1_sel    = ALU1_PC;
            alumux2_sel    = ALU2_J;
            pcmux_sel      = PC_ALU_MOD2;
            regfilemux_sel = RF_PC4;
          end
          OP_JALR: begin
            pcmux_sel      = PC_ALU_MOD2;
            regfilemux_sel = RF_PC4;
          end
          OP_BR: begin
            load_regfile = 1'b0;
            alumux1_sel  = ALU1_PC;
            alumux2_sel  = ALU2_B;
            pcmux_sel    = br_en ? PC_ALU : PC_PLUS4;
          end
          OP_IMM, OP_REG: begin
            if (opcode == OP_REG) alumux2_sel = ALU2_RS2;
            cmpmux_sel = (opcode == OP_REG) ? CMP_RS2 : CMP_I;
            case (funct3)
              3'b010: begin
                cmpop          = F3_BLT;
                regfilemux_sel = RF_BR;
              end
              3'b011: begin
                cmpop          = F3_BLTU;
                regfilemux_sel = RF_BR;
              end
              3'b101:  aluop = funct7[5] ? ALU_SRA : ALU_SRL;
              3'b000:  aluop = (opcode == OP_REG && funct7[5]) ? ALU_SUB : ALU_ADD;
              default: aluop = funct3;
            endcase
          end
          default: ;
        endcase
      end
      CALC_ADDR: begin
        if (opcode == OP_STORE) begin
          alumux2_sel   = ALU2_S;
          load_data_out = 1'b1;
        end
        if (ls_bad_f3) begin
          state_d = TRAP;
          cause_d = CAUSE_FUNCT3;
        end else if (MISALIGN_TRAP && ls_misaligned) begin
          state_d = TRAP;
          cause_d = (opcode == OP_STORE) ? CAUSE_MIS_ST : CAUSE_MIS_LD;
        end else begin
          load_mar   = 1'b1;
          marmux_sel = MAR_ALU;
          state_d    = (opcode == OP_STORE) ? ST1 : LD1;
        end
      end
      LD1: begin
        mem_read = 1'b1;
        load_mdr = 1'b1;
        rmask    = lane_q;
        if (mem_resp) state_d = LD2;
        else if (timeout_hit) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      LD2: begin
        rmask        = lane_q;
        load_regfile = 1'b1;
        load_pc      = 1'b1;
        state_d      = FETCH1;
        case (funct3)
          3'b000:  regfilemux_sel = RF_LB;
          3'b001:  regfilemux_sel = RF_LH;
          3'b100:  regfilemux_sel = RF_LBU;
          3'b101:  regfilemux_sel = RF_LHU;
          default: regfilemux_sel = RF_LW;
        endcase
      end
      ST1: begin
        mem_write       = 1'b1;
        mem_byte_enable = lane_q;
        wmask           = lane_q;
        if (mem_resp) state_d = ST2;
        else if (timeout_hit) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST2: begin
        mem_byte_enable = lane_q;
        wmask           = lane_q;
        load_pc         = 1'b1;
        state_d         = FETCH1;
      end
      HALT: begin
        if (!halt_req) state_d = FETCH1;
      end
      default: ;
    endcase
  end

  assign trap       = (state_q == TRAP);
  assign trap_cause = cause_q;
  assign halted     = (state_q == HALT);
  assign instret    = instret_q;

endmodule

// File: tb/tb_mc_control_v2.sv
// Directed bench for mc_control_v2: instance a (timeout 4, no misalign trap, 4-bit instret)
// and instance b (defaults) share stimulus; the one not under test is held in reset.
module tb_mc_control_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       br_en, mem_resp, halt_req;
  logic [1:0] addr_lsb;

  logic [1:0]  pcmux_a, pcmux_b;
  logic        alumux1_a, alumux1_b, marmux_a, marmux_b, cmpmux_a, cmpmux_b;
  logic [2:0]  alumux2_a, alumux2_b, aluop_a, aluop_b, cmpop_a, cmpop_b;
  logic [3:0]  rfmux_a, rfmux_b, mbe_a, mbe_b, rmask_a, rmask_b, wmask_a, wmask_b;
  logic        mem_read_a, mem_read_b, mem_write_a, mem_write_b;
  logic        load_pc_a, load_pc_b, load_ir_a, load_ir_b, load_rf_a, load_rf_b;
  logic        load_mar_a, load_mar_b, load_mdr_a, load_mdr_b, load_do_a, load_do_b;
  logic        trap_a, trap_b, halted_a, halted_b;
  logic [2:0]  cause_a, cause_b;
  logic [3:0]  instret_a;
  logic [31:0] instret_b;

  int nvec = 0;
  int nerr = 0;

  localparam logic [6:0] OP_BR = 7'b1100011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

  mc_control_v2 #(.MEM_TIMEOUT(4), .MISALIGN_TRAP(1'b0), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst_a), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_en(br_en), .addr_lsb(addr_lsb), .mem_resp(mem_resp), .halt_req(halt_req),
    .pcmux_sel(pcmux_a), .alumux1_sel(alumux1_a), .alumux2_sel(alumux2_a),
    .regfilemux_sel(rfmux_a), .marmux_sel(marmux_a), .cmpmux_sel(cmpmux_a),
    .aluop(aluop_a), .cmpop(cmpop_a), .mem_read(mem_read_a), .mem_write(mem_write_a),
    .mem_byte_enable(mbe_a), .rmask(rmask_a), .wmask(wmask_a), .load_pc(load_pc_a),
    .load_ir(load_ir_a), .load_regfile(load_rf_a), .load_mar(load_mar_a),
    .load_mdr(load_mdr_a), .load_data_out(load_do_a), .trap(trap_a),
    .trap_cause(cause_a), .halted(halted_a), .instret(instret_a));

  mc_control_v2 dut_b (
    .clk(clk), .rst(rst_b), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_en(br_en), .addr_lsb(addr_lsb), .mem_resp(mem_resp), .halt_req(halt_req),
    .pcmux_sel(pcmux_b), .alumux1_sel(alumux1_b), .alumux2_sel(alumux2_b),
    .regfilemux_sel(rfmux_b), .marmux_sel(marmux_b), .cmpmux_sel(cmpmux_b),
    .aluop(aluop_b), .cmpop(cmpop_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
    .mem_byte_enable(mbe_b), .rmask(rmask_b), .wmask(wmask_b), .load_pc(load_pc_b),
    .load_ir(load_ir_b), .load_regfile(load_rf_b), .load_mar(load_mar_b),
    .load_mdr(load_mdr_b), .load_data_out(load_do_b), .trap(trap_b),
    .trap_cause(cause_b), .halted(halted_b), .instret(instret_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH1; ends one cycle after DECODE (EXEC, CALC_ADDR or TRAP).
  task automatic fetch(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    tick();
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    opcode = '0; funct3 = '0; funct7 = '0;
    br_en = 1'b0; mem_resp = 1'b0; halt_req = 1'b0; addr_lsb = 2'b00;
    tick();
    tick();
    chk("a_rst_trap", trap_a, 0);
    chk("a_rst_cause", cause_a, 0);
    chk("a_rst_instret", instret_a, 0);
    chk("a_rst_halted", halted_a, 0);
    chk("a_rst_fetch1_mar", load_mar_a, 1);
    rst_a = 1'b0;

    // addi x1,x0,5
    fetch(OP_IMM, 3'b000, 7'd0);
    chk("a_addi_rf", load_rf_a, 1);
    chk("a_addi_pc", load_pc_a, 1);
    chk("a_addi_aluop", aluop_a, 0);
    tick();
    chk("a_instret1", instret_a, 1);

    // sw at addr 2 (misalign allowed)
    fetch(OP_STORE, 3'b010, 7'd0);
    addr_lsb = 2'b10;
    #1;
    chk("a_sw_mar", load_mar_a, 1);
    chk("a_sw_marmux", marmux_a, 1);
    chk("a_sw_dout", load_do_a, 1);
    chk("a_sw_alu2", alumux2_a, 3);
    tick();
    chk("a_sw_write", mem_write_a, 1);
    chk("a_sw_mbe", mbe_a, 4'b1111);
    chk("a_sw_wmask", wmask_a, 4'b1111);
    chk("a_sw_rmask", rmask_a, 0);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    chk("a_st2_pc", load_pc_a, 1);
    tick();

    // sh at addr 3: shifted mask truncates to the top lane
    fetch(OP_STORE, 3'b001, 7'd0);
    addr_lsb = 2'b11;
    tick();
    chk("a_sh_mbe", mbe_a, 4'b1000);
    chk("a_sh_wmask", wmask_a, 4'b1000);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    tick();
    chk("a_instret3", instret_a, 3);

    // lw: mem_resp on the 4th LD1 cycle wins over timeout
    fetch(OP_LOAD, 3'b010, 7'd0);
    addr_lsb = 2'b00;
    tick();
    chk("a_ld1_read", mem_read_a, 1);
    chk("a_ld1_rmask", rmask_a, 4'b1111);
    tick(); tick(); tick();
    mem_resp = 1'b1;
    #1;
    tick();
    mem_resp = 1'b0;
    chk("a_ld2_rf", load_rf_a, 1);
    chk("a_ld2_rfmux", rfmux_a, 3);
    chk("a_ld2_notrap", trap_a, 0);
    tick();
    chk("a_instret4", instret_a, 4);

    // lw: no mem_resp for 4 cycles -> timeout trap
    fetch(OP_LOAD, 3'b010, 7'd0);
    tick();
    tick(); tick(); tick();
    chk("a_to_wait_read", mem_read_a, 1);
    chk("a_to_wait_trap", trap_a, 0);
    tick();
    chk("a_to_trap", trap_a, 1);
    chk("a_to_cause", cause_a, 5);
    chk("a_to_read_off", mem_read_a, 0);
    tick();
    chk("a_to_sticky", trap_a, 1);
    chk("a_to_instret", instret_a, 4);
    rst_a = 1'b1;
    tick();
    chk("a_rst2_trap", trap_a, 0);
    chk("a_rst2_instret", instret_a, 0);
    rst_a = 1'b0;

    // 17 retires wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      fetch(OP_IMM, 3'b000, 7'd0);
      tick();
    end
    chk("a_wrap", instret_a, 1);

    // rst mid-ST1 wait
    fetch(OP_STORE, 3'b010, 7'd0);
    addr_lsb = 2'b00;
    tick();
    chk("a_st1_write", mem_write_a, 1);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("a_rst_st1_write", mem_write_a, 0);
    chk("a_rst_st1_mar", load_mar_a, 1);

    // halt_req during LD1 takes effect at the next FETCH1
    fetch(OP_LOAD, 3'b010, 7'd0);
    tick();
    halt_req = 1'b1;
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    chk("a_halt_ld2_rf", load_rf_a, 1);
    tick();
    chk("a_halt_f1_mar", load_mar_a, 0);
    chk("a_halt_instret", instret_a, 1);
    tick();
    chk("a_halted", halted_a, 1);
    tick();
    chk("a_halt_hold", halted_a, 1);
    halt_req = 1'b0;
    tick();
    chk("a_unhalt", halted_a, 0);
    chk("a_unhalt_mar", load_mar_a, 1);

    // instance b: defaults
    rst_a = 1'b1;
    rst_b = 1'b0;
    fetch(OP_BR, 3'b000, 7'd0);
    br_en = 1'b1;
    #1;
    chk("b_br_pcmux_t", pcmux_b, 1);
    chk("b_br_rf", load_rf_b, 0);
    chk("b_br_alu1", alumux1_b, 1);
    chk("b_br_alu2", alumux2_b, 2);
    br_en = 1'b0;
    #1;
    chk("b_br_pcmux_nt", pcmux_b, 0);
    tick();
    chk("b_instret1", instret_b, 1);

    fetch(OP_REG, 3'b010, 7'd0);
    chk("b_slt_rfmux", rfmux_b, 1);
    chk("b_slt_cmpop", cmpop_b, 3'b100);
    chk("b_slt_cmpmux", cmpmux_b, 0);
    chk("b_slt_alu2", alumux2_b, 5);
    tick();
    fetch(OP_REG, 3'b000, 7'b0100000);
    chk("b_sub_aluop", aluop_b, 3);
    tick();
    fetch(OP_IMM, 3'b101, 7'b0100000);
    chk("b_srai_aluop", aluop_b, 2);
    chk("b_srai_alu2", alumux2_b, 0);
    tick();
    chk("b_instret4", instret_b, 4);

    // timeout disabled: long wait does not trap
    fetch(OP_LOAD, 3'b010, 7'd0);
    addr_lsb = 2'b00;
    tick();
    repeat (10) tick();
    chk("b_nto_read", mem_read_b, 1);
    chk("b_nto_trap", trap_b, 0);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    chk("b_ld2_rmask", rmask_b, 4'b1111);
    tick();
    chk("b_instret5", instret_b, 5);

    // lh at 0x1001 traps misaligned
    fetch(OP_LOAD, 3'b001, 7'd0);
    addr_lsb = 2'b01;
    #1;
    chk("b_lh_mar", load_mar_b, 0);
    tick();
    chk("b_lh_trap", trap_b, 1);
    chk("b_lh_cause", cause_b, 3);
    chk("b_lh_instret", instret_b, 5);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    chk("b_rst_trap", trap_b, 0);
    chk("b_rst_cause", cause_b, 0);

    fetch(OP_STORE, 3'b010, 7'd0);
    addr_lsb = 2'b10;
    tick();
    chk("b_sw_mis_cause", cause_b, 4);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;

    fetch(7'b1111111, 3'b000, 7'd0);
    chk("b_illop_trap", trap_b, 1);
    chk("b_illop_cause", cause_b, 1);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;

    fetch(OP_BR, 3'b010, 7'd0);
    chk("b_brf3_cause", cause_b, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mc_control_v2.md
Name: mc_control_v2

Overview:
- Next-generation multicycle RV32I control FSM for the mp2 datapath.
- Drives all datapath mux selects, register loads and memory strobes, as the current controller does.
- Adds the following, which the current controller lacks:
  - precise trap detection (illegal opcode/funct3, misaligned access, memory timeout) with a sticky trap state;
  - an instruction-boundary halt;
  - a retired-instruction counter;
  - internal latching of the effective-address low bits for byte enables and load/store masks.

Parameters:
- MEM_TIMEOUT, 0, cycles FETCH2/LD1/ST1 may wait for mem_resp before a timeout trap; 0 disables the timeout.
- MISALIGN_TRAP, 1, 1 traps misaligned lw/lh/lhu/sw/sh; 0 lets them proceed with shifted masks.
- CNT_W, 32, width of instret.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- opcode  in  7  rv32i_opcode from IR.
- funct3  in  3  IR funct3.
- funct7  in  7  IR funct7.
- br_en  in  1  comparator result.
- addr_lsb  in  2  alu_out[1:0]; valid in CALC_ADDR.
- mem_resp  in  1  memory done.
- halt_req  in  1  debug halt request.
- pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel, cmpmux_sel  out  package widths  rv32i_types mux selects.
- aluop  out  3  alu_ops.
- cmpop  out  3  branch_funct3_t.
- mem_read, mem_write  out  1  memory strobes.
- mem_byte_enable  out  4  write byte enables.
- rmask, wmask  out  4  RVFI masks.
- load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out  out  1  register loads.
- trap  out  1  sticky trap flag.
- trap_cause  out  3  0 none, 1 illegal opcode, 2 illegal funct3, 3 misaligned load, 4 misaligned store, 5 memory timeout.
- halted  out  1  in HALT state.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- States: FETCH1, FETCH2, FETCH3, DECODE, EXEC, CALC_ADDR, LD1, LD2, ST1, ST2, TRAP, HALT. State is registered; rst forces FETCH1 on the next edge from any state, including mid-memory wait.
- Reset values and defaults:
  - After rst: trap=0, trap_cause=0, instret=0, halted=0, addr_q=0, timeout counter=0.
  - Every non-sticky output takes its default each cycle: all loads/strobes 0, mem_byte_enable=1111, pcmux=pc_plus4, alumux1=rs1_out, alumux2=i_imm, regfilemux=alu_out, marmux=pc_out, cmpmux=rs2_out, aluop=add, cmpop=funct3.
- FETCH1:
  - If halt_req=1, go to HALT (no MAR load).
  - Otherwise load_mar with pc_out and go to FETCH2.
- FETCH2:
  - mem_read=1 and load_mdr=1.
  - mem_resp=1 → FETCH3.
- FETCH3: load_ir → DECODE.
- DECODE (no outputs):
  - lui/auipc/jal/jalr/op_imm/op_reg → EXEC.
  - load/store → CALC_ADDR.
  - br → EXEC when funct3 ∈ {beq,bne,blt,bge,bltu,bgeu}; otherwise TRAP, cause 2.
  - Unknown opcode → TRAP, cause 1.
- EXEC: single-cycle execute for all non-memory ops, same selects as the existing controller:
  - slt/sltu via br_en with cmpop blt/bltu.
  - sr and add/sub split on funct7[5].
  - jal/jalr: regfilemux=pc_plus4, pcmux=alu_mod2. jalr uses rs1_out + i_imm.
  - br: pcmux = br_en ? alu_out : pc_plus4, ALU = pc + b_imm.
  - Always load_pc. load_regfile for everything except br.
  - Next state FETCH1.
- CALC_ADDR:
  - Compute address: load uses rs1 + i_imm; store uses rs1 + s_imm and asserts load_data_out.
  - Latch addr_q ← addr_lsb.
  - Illegal load funct3 (not lb/lh/lw/lbu/lhu) or store funct3 (not sb/sh/sw) → TRAP, cause 2.
  - If MISALIGN_TRAP=1: lw/sw with addr_lsb≠00, or half-word with addr_lsb[0]=1 → TRAP, cause 3 (load) or 4 (store). No MAR load.
  - Otherwise load_mar with alu_out → LD1 or ST1.
- LD1: mem_read=1 and load_mdr=1; mem_resp → LD2.
- LD2: load_regfile with the lw/lh/lhu/lb/lbu select per funct3, load_pc (pc_plus4) → FETCH1.
- ST1:
  - mem_write=1; mem_resp → ST2.
  - mem_byte_enable: sw 1111, sh 0011<<addr_q, sb 0001<<addr_q. Shift is 4-bit and truncated; with MISALIGN_TRAP=0, sh at addr_q=11 yields 1000.
- ST2: load_pc (pc_plus4) → FETCH1.
- rmask/wmask:
  - rmask follows the same shift rule as mem_byte_enable (lw 1111, lh/lhu 0011<<addr_q, lb/lbu 0001<<addr_q); nonzero only in LD1/LD2.
  - wmask equals mem_byte_enable in ST1/ST2.
  - Both 0 elsewhere.
- Timeout:
  - Counter clears on entry to FETCH2/LD1/ST1 and increments each cycle mem_resp=0.
  - If MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT with mem_resp=0 → TRAP, cause 5. mem_read/mem_write are deasserted from the next cycle.
  - If mem_resp and the timeout coincide, mem_resp wins.
- TRAP:
  - trap=1, all loads/strobes 0.
  - trap_cause holds the first cause; state stays in TRAP until rst.
- HALT:
  - halted=1, no loads.
  - halt_req=0 → FETCH1. Halt takes effect only at FETCH1, never mid-instruction.
- instret:
  - +1 (mod 2^CNT_W) on every cycle where load_pc=1.
  - Trapped instructions do not retire.

Test Plan:
- addi x1,x0,5; sw x1,2(x0) with MISALIGN_TRAP=0 → store byte-enable wraps to 0100? no: sw at addr_q=10 gives mem_byte_enable=1111; then sh at addr 3 gives mem_byte_enable=1000 and wmask=1000; instret=3 after 3 retires.
- lh at address 0x1001, MISALIGN_TRAP=1 → TRAP from CALC_ADDR with trap=1, trap_cause=3, load_mar never asserted, instret unchanged; pulse rst → FETCH1 with trap=0.
- Opcode 7'b1111111 → DECODE→TRAP, trap_cause=1. Branch with funct3=010 → trap_cause=2.
- MEM_TIMEOUT=4, mem_resp held 0 in LD1 → TRAP 4 cycles after LD1 entry, cause 5, mem_read=0 from the next cycle. Same run with mem_resp=1 on cycle 4 → LD2, no trap.
- halt_req=1 during LD1 → load completes, instret increments, then HALT at the next FETCH1 with halted=1; deassert → FETCH1 with load_mar=1.
- CNT_W=4: retire 17 instructions → instret=1 (wrap). rst asserted in ST1 mid-wait → FETCH1 next cycle with mem_write=0.
